// File: rtl/vai_pkg.sv
// Shared types and defaults for the VAI Tx buffer: CCI-P Tx port layout and FIFO entry formats.
package vai_pkg;

    localparam int VAI_DEPTH_DEFAULT         = 32;
    localparam int VAI_ALMFULL_SLACK_DEFAULT = 10;

    localparam int C0_HDR_W  = 74;
    localparam int C1_HDR_W  = 80;
    localparam int CL_DATA_W = 512;
    localparam int C2_HDR_W  = 9;
    localparam int C2_DATA_W = 64;

    typedef logic [C0_HDR_W-1:0] t_vai_c0_entry;

    typedef struct packed {
        logic [C1_HDR_W-1:0]  hdr;
        logic [CL_DATA_W-1:0] data;
    } t_vai_c1_entry;

    typedef struct packed {
        logic [C0_HDR_W-1:0] hdr;
        logic                valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        logic [C1_HDR_W-1:0]  hdr;
        logic [CL_DATA_W-1:0] data;
        logic                 valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        logic [C2_HDR_W-1:0]  hdr;
        logic                 mmioRdValid;
        logic [C2_DATA_W-1:0] data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

endpackage

// File: rtl/vai_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is ignored, a pop while empty is ignored.
module vai_sync_fifo #(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 32,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] pushData,
    input  logic              pop,
    output logic [DATA_W-1:0] popData,
    output logic              full,
    output logic              empty,
    output logic [PTR_W:0]    count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic              pushOk;
    logic              popOk;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pushOk  = push && !full;
    assign popOk   = pop && !empty;
    assign popData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (pushOk) mem[wrPtr] <= pushData;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
            if (popOk)  rdPtr <= rdPtr + PTR_W'(1);
            count <= count + (PTR_W+1)'(pushOk) - (PTR_W+1)'(popOk);
        end
    end

endmodule

// File: rtl/vai_tx_buffer.sv
// Per-slot Tx buffer: independent c0/c1 FIFOs with registered outputs, c2 passes through one register.
// Optional statistics outputs enabled by defining VAI_TX_BUFFER_STATS_EN.
module vai_tx_buffer
    import vai_pkg::*;
#(
    parameter int DEPTH         = VAI_DEPTH_DEFAULT,
    parameter int ALMFULL_SLACK = VAI_ALMFULL_SLACK_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  t_if_ccip_Tx afu_TxPort,
    output logic        afu_c0_almFull,
    output logic        afu_c1_almFull,
    output t_if_ccip_Tx out_TxPort,
    input  logic        in_c0_almFull,
    input  logic        in_c1_almFull,
    output logic        overflow_err
`ifdef VAI_TX_BUFFER_STATS_EN
    ,
    output logic [63:0]            c0_push_cnt,
    output logic [63:0]            c1_push_cnt,
    output logic [$clog2(DEPTH):0] c0_max_occ,
    output logic [$clog2(DEPTH):0] c1_max_occ
`endif
);

    localparam int              CNT_W       = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] ALMFULL_THR = CNT_W'(DEPTH - ALMFULL_SLACK);

    logic             c0Full, c0Empty, c0Pop;
    logic             c1Full, c1Empty, c1Pop;
    logic [CNT_W-1:0] c0Count, c1Count;
    t_vai_c0_entry    c0PopData;
    t_vai_c1_entry    c1PushData, c1PopData;

    t_vai_c0_entry        c0Hdr_p1;
    logic                 c0Vld_p1;
    t_vai_c1_entry        c1Ent_p1;
    logic                 c1Vld_p1;
    logic [C2_HDR_W-1:0]  c2Hdr_p1;
    logic [C2_DATA_W-1:0] c2Data_p1;
    logic                 c2Vld_p1;

    assign c1PushData = '{hdr: afu_TxPort.c1.hdr, data: afu_TxPort.c1.data};
    assign c0Pop      = !c0Empty && !in_c0_almFull;
    assign c1Pop      = !c1Empty && !in_c1_almFull;

    vai_sync_fifo #(.DATA_W($bits(t_vai_c0_entry)), .DEPTH(DEPTH)) c0Fifo (
        .clk(clk), .reset(reset),
        .push(afu_TxPort.c0.valid), .pushData(afu_TxPort.c0.hdr),
        .pop(c0Pop), .popData(c0PopData),
        .full(c0Full), .empty(c0Empty), .count(c0Count)
    );

    vai_sync_fifo #(.DATA_W($bits(t_vai_c1_entry)), .DEPTH(DEPTH)) c1Fifo (
        .clk(clk), .reset(reset),
        .push(afu_TxPort.c1.valid), .pushData(c1PushData),
        .pop(c1Pop), .popData(c1PopData),
        .full(c1Full), .empty(c1Empty), .count(c1Count)
    );

    // p0 -> p1: payload registers carry no reset, only the qualifiers do
    always_ff @(posedge clk) begin
        c0Hdr_p1  <= c0PopData;
        c1Ent_p1  <= c1PopData;
        c2Hdr_p1  <= afu_TxPort.c2.hdr;
        c2Data_p1 <= afu_TxPort.c2.data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c0Vld_p1       <= 1'b0;
            c1Vld_p1       <= 1'b0;
            c2Vld_p1       <= 1'b0;
            afu_c0_almFull <= 1'b1;
            afu_c1_almFull <= 1'b1;
            overflow_err   <= 1'b0;
        end else begin
            c0Vld_p1       <= c0Pop;
            c1Vld_p1       <= c1Pop;
            c2Vld_p1       <= afu_TxPort.c2.mmioRdValid;
            afu_c0_almFull <= (c0Count >= ALMFULL_THR);
            afu_c1_almFull <= (c1Count >= ALMFULL_THR);
            if ((afu_TxPort.c0.valid && c0Full) || (afu_TxPort.c1.valid && c1Full))
                overflow_err <= 1'b1;
        end
    end

    always_comb begin
        out_TxPort                = '0;
        out_TxPort.c0.hdr         = c0Hdr_p1;
        out_TxPort.c0.valid       = c0Vld_p1;
        out_TxPort.c1.hdr         = c1Ent_p1.hdr;
        out_TxPort.c1.data        = c1Ent_p1.data;
        out_TxPort.c1.valid       = c1Vld_p1;
        out_TxPort.c2.hdr         = c2Hdr_p1;
        out_TxPort.c2.data        = c2Data_p1;
        out_TxPort.c2.mmioRdValid = c2Vld_p1;
    end

`ifdef VAI_TX_BUFFER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            c0_push_cnt <= '0;
            c1_push_cnt <= '0;
            c0_max_occ  <= '0;
            c1_max_occ  <= '0;
        end else begin
            c0_push_cnt <= c0_push_cnt + 64'(afu_TxPort.c0.valid && !c0Full);
            c1_push_cnt <= c1_push_cnt + 64'(afu_TxPort.c1.valid && !c1Full);
            if (c0Count > c0_max_occ) c0_max_occ <= c0Count;
            if (c1Count > c1_max_occ) c1_max_occ <= c1Count;
        end
    end
`endif

endmodule
